// File: rtl/mod_wrap_tracker.sv
// Watches the output of an upstream modulo-UPTO counter, counts its wraps modulo WRAPS
// and latches an error on any illegal step.
module mod_wrap_tracker #(
  parameter int UPTO  = 11,
  parameter int NBITS = 4,
  parameter int WRAPS = 10,
  parameter int WBITS = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [NBITS-1:0] q_in,
  output logic             tick,
  output logic             carry,
  output logic [WBITS-1:0] wrap_count,
  output logic             err,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    TRACK = 2'b01,
    ERROR = 2'b10
  } state_t;

  localparam logic [NBITS:0]   LIM   = (NBITS+1)'(UPTO);
  localparam logic [NBITS:0]   LAST  = (NBITS+1)'(UPTO - 1);
  localparam logic [WBITS-1:0] WLAST = WBITS'(WRAPS - 1);

  state_t           st;
  logic [NBITS-1:0] prev;
  logic [NBITS:0]   prev_x, q_x, expected;
  logic             step_ok, stall, is_wrap, wc_last;

  // One extra bit so prev+1 cannot overflow when UPTO fills the NBITS range.
  assign prev_x   = {1'b0, prev};
  assign q_x      = {1'b0, q_in};
  assign expected = (prev_x == LAST) ? '0 : prev_x + (NBITS+1)'(1);

  // The step match is tested before the stall match so that with UPTO==1 a
  // repeated 0 counts as a wrap rather than a stall.
  assign step_ok  = (q_x == expected);
  assign stall    = (q_in == prev);
  assign is_wrap  = step_ok && (prev_x == LAST);
  assign wc_last  = (wrap_count == WLAST);

  assign state    = st;

  always_ff @(posedge clk) begin
    if (clear) begin
      st         <= IDLE;
      prev       <= '0;
      wrap_count <= '0;
      tick       <= 1'b0;
      carry      <= 1'b0;
      err        <= 1'b0;
    end else begin
      tick  <= 1'b0;
      carry <= 1'b0;
      case (st)
        IDLE: begin
          if (en) begin
            if (q_x < LIM) begin
              prev <= q_in;
              st   <= TRACK;
            end else begin
              st  <= ERROR;
              err <= 1'b1;
            end
          end
        end
        TRACK: begin
          if (en) begin
            if (step_ok) begin
              prev <= q_in;
              if (is_wrap) begin
                tick       <= 1'b1;
                carry      <= wc_last;
                wrap_count <= wc_last ? '0 : wrap_count + WBITS'(1);
              end
            end else if (!stall) begin
              st  <= ERROR;
              err <= 1'b1;
            end
          end
        end
        ERROR: begin
          err <= 1'b1;
        end
        default: begin
          st  <= ERROR;
          err <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_wrap_tracker.sv
// Bench for mod_wrap_tracker: constant vector table, directed corner sequences,
// and randomized traffic checked against an arithmetic reference model.
module tb_mod_wrap_tracker;

  localparam int UPTO  = 11;
  localparam int WRAPS = 10;

  logic       clk;
  logic       clear, en;
  logic [3:0] q_in;
  logic       tick, carry, err;
  logic [3:0] wrap_count;
  logic [1:0] state;

  logic       clr1, en1;
  logic [1:0] q1;
  logic       tick1, carry1, err1;
  logic [1:0] wc1, state1;

  mod_wrap_tracker #(.UPTO(UPTO), .NBITS(4), .WRAPS(WRAPS), .WBITS(4)) dut (
    .clk(clk), .clear(clear), .en(en), .q_in(q_in),
    .tick(tick), .carry(carry), .wrap_count(wrap_count), .err(err), .state(state)
  );

  mod_wrap_tracker #(.UPTO(1), .NBITS(2), .WRAPS(3), .WBITS(2)) dut1 (
    .clk(clk), .clear(clr1), .en(en1), .q_in(q1),
    .tick(tick1), .carry(carry1), .wrap_count(wc1), .err(err1), .state(state1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode 0 idle, 1 tracking, 2 error; total wrap count kept unbounded.
  int m_mode, m_prev, m_wraps;
  bit m_tick, m_carry, m_err;

  task automatic model_step(input bit c, input bit e, input int q);
    if (c) begin
      m_mode = 0; m_prev = 0; m_wraps = 0; m_tick = 0; m_carry = 0; m_err = 0;
    end else begin
      m_tick = 0; m_carry = 0;
      if (e) begin
        case (m_mode)
          0: if (q < UPTO) begin m_prev = q; m_mode = 1; end
             else begin m_mode = 2; m_err = 1; end
          1: if (q == (m_prev + 1) % UPTO) begin
               if (m_prev + 1 == UPTO) begin
                 m_wraps++;
                 m_tick  = 1;
                 m_carry = (m_wraps % WRAPS == 0);
               end
               m_prev = q;
             end else if (q != m_prev) begin
               m_mode = 2; m_err = 1;
             end
          default: ;
        endcase
      end
    end
  endtask

  task automatic check_model(input string name);
    n_tests++;
    if (tick !== m_tick || carry !== m_carry || wrap_count !== 4'(m_wraps % WRAPS) ||
        err !== m_err || state !== 2'(m_mode)) begin
      n_fail++;
      $display("FAIL %s: got tick=%0b carry=%0b wc=%0d err=%0b st=%0d, want tick=%0b carry=%0b wc=%0d err=%0b st=%0d",
               name, tick, carry, wrap_count, err, state,
               m_tick, m_carry, m_wraps % WRAPS, m_err, m_mode);
    end
  endtask

  task automatic check_exp(input string name, input logic t, input logic c,
                           input logic [3:0] wc, input logic e, input logic [1:0] s);
    n_tests++;
    if (tick !== t || carry !== c || wrap_count !== wc || err !== e || state !== s) begin
      n_fail++;
      $display("FAIL %s: got tick=%0b carry=%0b wc=%0d err=%0b st=%0d, want tick=%0b carry=%0b wc=%0d err=%0b st=%0d",
               name, tick, carry, wrap_count, err, state, t, c, wc, e, s);
    end
  endtask

  task automatic step(input bit c, input bit e, input int q, input string name);
    clear = c; en = e; q_in = 4'(q);
    @(posedge clk); #1;
    model_step(c, e, q);
    check_model(name);
  endtask

  task automatic step1(input bit c, input bit e, input int q, input string name,
                       input logic t, input logic cy, input logic [1:0] wc,
                       input logic e_err, input logic [1:0] s);
    clr1 = c; en1 = e; q1 = 2'(q);
    @(posedge clk); #1;
    n_tests++;
    if (tick1 !== t || carry1 !== cy || wc1 !== wc || err1 !== e_err || state1 !== s) begin
      n_fail++;
      $display("FAIL %s: got tick=%0b carry=%0b wc=%0d err=%0b st=%0d, want tick=%0b carry=%0b wc=%0d err=%0b st=%0d",
               name, tick1, carry1, wc1, err1, state1, t, cy, wc, e_err, s);
    end
  endtask

  typedef struct {
    bit         clr;
    bit         en;
    int         q;
    logic       t;
    logic       c;
    logic [3:0] wc;
    logic       e;
    logic [1:0] s;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit clr, bit en_v, int q, logic t, logic c,
                              logic [3:0] wc, logic e, logic [1:0] s);
    vec_t v;
    v.clr = clr; v.en = en_v; v.q = q; v.t = t; v.c = c; v.wc = wc; v.e = e; v.s = s;
    vecs.push_back(v);
  endfunction

  task automatic seed_wraps(input int n);
    step(1, 0, 0, "seed_clear");
    step(0, 1, 0, "seed_first");
    for (int w = 0; w < n; w++) begin
      for (int v = 1; v <= 10; v++) step(0, 1, v, "seed_up");
      step(0, 1, 0, "seed_wrap");
    end
  endtask

  bit prev_tick, prev_carry;

  initial begin
    clear = 1; en = 0; q_in = 0;
    clr1 = 1; en1 = 0; q1 = 0;
    @(posedge clk); #1;
    model_step(1, 0, 0);
    check_model("reset_state");

    // Nominal count, stall, enable-low hold, illegal step, out-of-range.
    add(1, 0, 0,  0, 0, 0, 0, 2'b00);
    for (int v = 0; v <= 10; v++) add(0, 1, v, 0, 0, 0, 0, 2'b01);
    add(0, 1, 0,  1, 0, 1, 0, 2'b01);
    add(0, 1, 0,  0, 0, 1, 0, 2'b01);
    add(0, 0, 7,  0, 0, 1, 0, 2'b01);
    add(0, 1, 1,  0, 0, 1, 0, 2'b01);
    add(1, 1, 9,  0, 0, 0, 0, 2'b00);
    add(0, 1, 3,  0, 0, 0, 0, 2'b01);
    add(0, 1, 5,  0, 0, 0, 1, 2'b10);
    add(0, 1, 10, 0, 0, 0, 1, 2'b10);
    add(0, 1, 0,  0, 0, 0, 1, 2'b10);
    add(1, 0, 0,  0, 0, 0, 0, 2'b00);
    add(0, 1, 12, 0, 0, 0, 1, 2'b10);
    add(1, 0, 0,  0, 0, 0, 0, 2'b00);
    add(0, 1, 11, 0, 0, 0, 1, 2'b10);
    add(1, 0, 0,  0, 0, 0, 0, 2'b00);
    add(0, 1, 10, 0, 0, 0, 0, 2'b01);
    add(0, 1, 15, 0, 0, 0, 1, 2'b10);
    add(1, 0, 0,  0, 0, 0, 0, 2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].clr, vecs[i].en, vecs[i].q, $sformatf("vec%0d_model", i));
      check_exp($sformatf("vec%0d", i), vecs[i].t, vecs[i].c, vecs[i].wc, vecs[i].e, vecs[i].s);
    end

    // Rollover: ten wraps bring wrap_count back to 0 with carry and tick together.
    seed_wraps(9);
    check_exp("roll_wc9", 1, 0, 9, 0, 2'b01);
    for (int v = 1; v <= 10; v++) step(0, 1, v, "roll_up");
    step(0, 1, 0, "roll_wrap");
    check_exp("roll_carry", 1, 1, 0, 0, 2'b01);
    step(0, 1, 1, "roll_after");
    check_exp("roll_single", 0, 0, 0, 0, 2'b01);

    // Stall and enable-low hold, then the next legal value is accepted.
    step(1, 0, 0, "stall_clear");
    for (int v = 0; v <= 5; v++) step(0, 1, v, "stall_up");
    step(0, 1, 5, "stall_rep1");
    step(0, 1, 5, "stall_rep2");
    for (int i = 0; i < 6; i++) step(0, 0, $urandom_range(0, 15), "en_low");
    check_exp("hold_state", 0, 0, 0, 0, 2'b01);
    step(0, 1, 6, "accept6");
    step(0, 1, 7, "accept7");
    check_exp("after_stall", 0, 0, 0, 0, 2'b01);

    // Clear on the cycle the 10 -> 0 sample lands with wrap_count at 9.
    seed_wraps(9);
    for (int v = 1; v <= 10; v++) step(0, 1, v, "coll_up");
    step(1, 1, 0, "coll_clear");
    check_exp("coll_result", 0, 0, 0, 0, 2'b00);
    step(0, 1, 0, "coll_seed");
    check_exp("coll_seed_notick", 0, 0, 0, 0, 2'b01);

    // Degenerate modulus: every accepted 0 after the first is a wrap.
    clear = 0; en = 0;
    step1(1, 0, 0, "u1_clear", 0, 0, 2'd0, 0, 2'b00);
    step1(0, 1, 0, "u1_seed",  0, 0, 2'd0, 0, 2'b01);
    step1(0, 0, 0, "u1_gap1",  0, 0, 2'd0, 0, 2'b01);
    step1(0, 1, 0, "u1_wrap1", 1, 0, 2'd1, 0, 2'b01);
    step1(0, 0, 0, "u1_gap2",  0, 0, 2'd1, 0, 2'b01);
    step1(0, 1, 0, "u1_wrap2", 1, 0, 2'd2, 0, 2'b01);
    step1(0, 0, 0, "u1_gap3",  0, 0, 2'd2, 0, 2'b01);
    step1(0, 1, 0, "u1_wrap3", 1, 1, 2'd0, 0, 2'b01);
    step1(0, 1, 1, "u1_bad",   0, 0, 2'd0, 1, 2'b10);
    step1(1, 0, 0, "u1_reclr", 0, 0, 2'd0, 0, 2'b00);

    // Randomized traffic, biased toward legal steps so wraps and carries occur.
    step(1, 0, 0, "rnd_clear");
    prev_tick = 0; prev_carry = 0;
    for (int i = 0; i < 4000; i++) begin
      int r, q;
      bit c, e;
      r = $urandom_range(0, 99);
      if (r < 72)      q = (m_prev + 1) % UPTO;
      else if (r < 84) q = m_prev;
      else             q = $urandom_range(0, 15);
      c = ($urandom_range(0, 199) == 0) || (m_mode == 2 && $urandom_range(0, 7) == 0);
      e = ($urandom_range(0, 3) != 0);
      step(c, e, q, "random");
      n_tests++;
      if ((tick && prev_tick) || (carry && prev_carry)) begin
        n_fail++;
        $display("FAIL pulse_width: got tick=%0b/%0b carry=%0b/%0b on consecutive cycles, want no back-to-back pulse",
                 prev_tick, tick, prev_carry, carry);
      end
      prev_tick = tick; prev_carry = carry;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
